// File: rtl/image_memory_arbiter.sv
// Frame-buffer arbiter: one synchronous-read RAM shared by VGA scan-out, a host
// pixel-write port and a fill engine. Display has top priority, then fill, then host.
module image_memory_arbiter #(
    parameter int unsigned H_IMAGE = 240,
    parameter int unsigned V_IMAGE = 320,
    parameter int unsigned PIXEL_W = 3,
    localparam int unsigned ADDR_W = $clog2(H_IMAGE * V_IMAGE)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [10:0]        pixel_x,
    input  logic [10:0]        pixel_y,
    input  logic               video_on,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               fill_start,
    input  logic [PIXEL_W-1:0] fill_color,
    output logic               fill_busy,
    output logic               fill_done,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [PIXEL_W-1:0] mem_wdata,
    input  logic [PIXEL_W-1:0] mem_rdata,
    output logic               color_r,
    output logic               color_g,
    output logic               color_b
);

    localparam int unsigned      NumPix   = H_IMAGE * V_IMAGE;
    localparam logic [10:0]      HLim     = 11'(H_IMAGE);
    localparam logic [10:0]      VLim     = 11'(V_IMAGE);
    localparam logic [ADDR_W:0]  NumPixW  = (ADDR_W + 1)'(NumPix);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPix - 1);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e              state_q, state_d;
    logic                disp;
    logic                fill_accept;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
    logic [PIXEL_W-1:0]  fill_color_q, fill_color_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [PIXEL_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [1:0]          disp_q;
    logic [PIXEL_W-1:0]  color_q, color_d;

    assign disp        = video_on && (pixel_x < HLim) && (pixel_y < VLim);
    assign fill_accept = (state_q == StIdle) && fill_start;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; disp cycles stall the fill
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fill_start) state_d = StFill;
            StFill:  if (!disp && (fill_addr_q == LastAddr)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        wr_ready  = 1'b0;
        fill_busy = 1'b0;
        fill_done = 1'b0;
        unique case (state_q)
            StIdle:  wr_ready  = !disp;
            StFill:  fill_busy = 1'b1;
            StDone:  fill_done = 1'b1;
            default: ;
        endcase
    end

    // RAM port mux; an idle cycle keeps the last address and data
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        if (disp) begin
            mem_addr_d = rd_cnt_q;
        end else if (state_q == StFill) begin
            mem_addr_d  = fill_addr_q;
            mem_we_d    = 1'b1;
            mem_wdata_d = fill_color_q;
        end else if (wr_valid && wr_ready) begin
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            mem_we_d    = ({1'b0, wr_addr} < NumPixW);
        end
    end

    // Counters and colour stage
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (pixel_y >= VLim) begin
            rd_cnt_d = '0;
        end else if (disp) begin
            rd_cnt_d = (rd_cnt_q == LastAddr) ? '0 : rd_cnt_q + ADDR_W'(1);
        end

        fill_addr_d  = fill_addr_q;
        fill_color_d = fill_color_q;
        if (fill_accept) begin
            fill_addr_d  = '0;
            fill_color_d = fill_color;
        end else if ((state_q == StFill) && !disp) begin
            fill_addr_d = (fill_addr_q == LastAddr) ? '0 : fill_addr_q + ADDR_W'(1);
        end

        color_d = disp_q[1] ? mem_rdata : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q     <= '0;
            fill_addr_q  <= '0;
            fill_color_q <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            disp_q       <= '0;
            color_q      <= '0;
        end else begin
            rd_cnt_q     <= rd_cnt_d;
            fill_addr_q  <= fill_addr_d;
            fill_color_q <= fill_color_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            disp_q       <= {disp_q[0], disp};
            color_q      <= color_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign color_r   = color_q[2];
    assign color_g   = color_q[1];
    assign color_b   = color_q[0];

endmodule

// File: tb/tb_image_memory_arbiter.sv
// Randomised bench for image_memory_arbiter against a cycle-level reference model
// holding its own copy of the frame buffer.
module tb_image_memory_arbiter;

    localparam int H = 240;
    localparam int V = 320;
    localparam int N = H * V;
    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_DONE = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] pixel_x = '0;
    logic [10:0] pixel_y = '0;
    logic        video_on = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [16:0] wr_addr = '0;
    logic [2:0]  wr_data = '0;
    logic        fill_start = 1'b0;
    logic [2:0]  fill_color = '0;
    logic        fill_busy;
    logic        fill_done;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;
    logic        color_r;
    logic        color_g;
    logic        color_b;

    image_memory_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .color_r    (color_r),
        .color_g    (color_g),
        .color_b    (color_b)
    );

    always #5 clock = ~clock;

    // Write-first single-port RAM
    logic [2:0] ram [0:131071];
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [2:0] model_mem [0:N-1];
    int         m_state;
    int         m_fill_addr;
    int         m_rd;
    logic [2:0] m_fill_color;
    logic       exp_we;
    int         exp_addr;
    logic [2:0] exp_wdata;
    logic [2:0] pipe [3];
    bit         host_acc;

    bit count_en = 1'b0;
    int busy_cnt = 0;
    int done_cnt = 0;
    always @(negedge clock) begin
        if (count_en) begin
            busy_cnt += int'(fill_busy);
            done_cnt += int'(fill_done);
        end
    end

    function automatic bit disp_now();
        return video_on && (int'(pixel_x) < H) && (int'(pixel_y) < V);
    endfunction

    task automatic model_reset();
        m_state      = M_IDLE;
        m_fill_addr  = 0;
        m_rd         = 0;
        m_fill_color = '0;
        exp_we       = 1'b0;
        exp_addr     = 0;
        exp_wdata    = '0;
        host_acc     = 1'b0;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
    endtask

    // Advance the model over one clock edge using the inputs of the ending cycle
    task automatic model_step();
        bit         d;
        bit         nwe;
        int         naddr;
        logic [2:0] ndata;
        logic [2:0] col;
        d = disp_now();
        if (exp_we) model_mem[exp_addr] = exp_wdata;
        nwe = 1'b0; naddr = exp_addr; ndata = exp_wdata; col = '0; host_acc = 1'b0;
        if (d) begin
            naddr = m_rd;
            col   = model_mem[m_rd];
        end else if (m_state == M_FILL) begin
            nwe = 1'b1; naddr = m_fill_addr; ndata = m_fill_color;
        end else if (m_state == M_IDLE && wr_valid) begin
            host_acc = 1'b1;
            naddr    = int'(wr_addr);
            ndata    = wr_data;
            nwe      = int'(wr_addr) < N;
        end
        case (m_state)
            M_IDLE: if (fill_start) begin
                m_state = M_FILL; m_fill_addr = 0; m_fill_color = fill_color;
            end
            M_FILL: if (!d) begin
                if (m_fill_addr == N - 1) m_state = M_DONE;
                m_fill_addr++;
            end
            default: m_state = M_IDLE;
        endcase
        if (int'(pixel_y) >= V) m_rd = 0;
        else if (d) m_rd = (m_rd + 1) % N;
        pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = col;
        exp_we = nwe; exp_addr = naddr; exp_wdata = ndata;
    endtask

    task automatic check_outputs();
        check("wr_ready", 32'(wr_ready), 32'(m_state == M_IDLE && !disp_now()));
        check("fill_busy", 32'(fill_busy), 32'(m_state == M_FILL));
        check("fill_done", 32'(fill_done), 32'(m_state == M_DONE));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_we) check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        check("color", 32'({color_r, color_g, color_b}), 32'(pipe[2]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_color"}, 32'({color_r, color_g, color_b}), 32'd0);
        check({tag, "_fill_busy"}, 32'(fill_busy), 32'd0);
        check({tag, "_fill_done"}, 32'(fill_done), 32'd0);
    endtask

    task automatic step();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_step();
        #1;
    endtask

    // Host keeps a request stable until accepted, then maybe issues another
    task automatic drive_host();
        if (host_acc || !wr_valid) begin
            if ($urandom_range(0, 2) == 0) begin
                wr_valid = 1'b1;
                wr_addr  = ($urandom_range(0, 15) == 0) ? 17'(N + $urandom_range(0, 100))
                                                       : 17'($urandom_range(0, 511));
                wr_data  = 3'($urandom_range(0, 7));
            end else begin
                wr_valid = 1'b0;
            end
        end
    endtask

    task automatic sweep(input string tag);
        for (int k = 0; k < N; k++) check(tag, 32'(ram[k]), 32'(model_mem[k]));
    endtask

    initial begin
        for (int k = 0; k < 131072; k++) ram[k] = 3'(k % 8);
        for (int k = 0; k < N; k++) model_mem[k] = 3'(k % 8);
        model_reset();

        // Reset and idle
        @(negedge clock);
        check_zero("in_reset");
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (5) step();

        // Directed host writes: outside disp, blocked by disp, out of range
        pixel_x = 11'd300; pixel_y = 11'd0; video_on = 1'b1;
        wr_valid = 1'b1; wr_addr = 17'd481; wr_data = 3'b110;
        step();
        wr_addr = 17'd481; wr_data = 3'b101; pixel_x = 11'd10;
        repeat (3) step();
        pixel_x = 11'd300;
        step();
        wr_addr = 17'(N); wr_data = 3'b111;
        step();
        wr_valid = 1'b0; pixel_y = 11'(V + 1); video_on = 1'b0;
        repeat (3) step();

        // Two frames of a short raster with random host traffic
        for (int f = 0; f < 2; f++) begin
            for (int y = 0; y < 3; y++) begin
                for (int x = 0; x < 260; x++) begin
                    pixel_x = 11'(x); pixel_y = 11'(y); video_on = (x < 250);
                    drive_host();
                    step();
                end
            end
            for (int k = 0; k < 10; k++) begin
                pixel_x = 11'(k); pixel_y = 11'(V + 5); video_on = 1'b0;
                drive_host();
                step();
            end
        end

        // Fill under active video, then reset once 1000 fill writes are issued
        wr_valid = 1'b0;
        fill_color = 3'b101; fill_start = 1'b1;
        pixel_x = 11'd0; pixel_y = 11'd0; video_on = 1'b1;
        step();
        begin
            int cyc = 1;
            while (!(m_state == M_FILL && m_fill_addr == 1000) && cyc < 20000) begin
                pixel_x    = 11'(cyc % 300);
                pixel_y    = 11'((cyc / 300) % 4);
                video_on   = 1'($urandom_range(0, 1));
                fill_start = ($urandom_range(0, 63) == 0);
                fill_color = 3'($urandom_range(0, 7));
                drive_host();
                step();
                cyc++;
            end
            check("fill_reach_1000", 32'(m_fill_addr), 32'd1000);
        end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_zero("mid_fill_reset");
        model_reset();
        wr_valid = 1'b0; fill_start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int k = 1000; k < 1010; k++) check("untouched", 32'(ram[k]), 32'(k % 8));
        sweep("ram_after_abort");
        step();
        check("idle_after_abort", 32'(wr_ready), 32'(!disp_now()));

        // Full fill with video off; a second fill_start while busy is ignored
        video_on = 1'b0; pixel_x = 11'd0; pixel_y = 11'd0;
        fill_color = 3'b011; fill_start = 1'b1;
        busy_cnt = 0; done_cnt = 0; count_en = 1'b1;
        step();
        fill_start = 1'b0;
        for (int c = 0; c < 80000 && m_state != M_IDLE; c++) begin
            fill_start = (c == 100);
            fill_color = (c == 100) ? 3'b101 : 3'b011;
            step();
        end
        fill_start = 1'b0;
        repeat (4) step();
        count_en = 1'b0;
        check("busy_cycles", 32'(busy_cnt), 32'(N));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("busy_after", 32'(fill_busy), 32'd0);
        check("ram_first", 32'(ram[0]), 32'(3'b011));
        check("ram_last", 32'(ram[N-1]), 32'(3'b011));
        sweep("ram_after_fill");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/image_memory_arbiter.md
Name: image_memory_arbiter

Overview:
- Shares one single-port, synchronous-read frame-buffer RAM between three users:
  - the VGA scan-out reader,
  - a host pixel-write port with a valid/ready handshake,
  - a hardware fill engine that clears the image to one colour.
- The image occupies the top-left H_IMAGE x V_IMAGE region of the screen.
- Sits between the VGA timing generator (pixel_x, pixel_y, video_on) and the frame-buffer RAM, and drives the 3-bit RGB pixel outputs.

Parameters:
- H_IMAGE, 240, image width in pixels
- V_IMAGE, 320, image height in lines
- PIXEL_W, 3, bits per pixel: bit2 = R, bit1 = G, bit0 = B
- ADDR_W, $clog2(H_IMAGE*V_IMAGE) = 17, RAM address width (derived; do not override)

Ports:
- clock  in  1  system/pixel clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- pixel_x  in  11  current scan column
- pixel_y  in  11  current scan line
- video_on  in  1  visible-area flag
- wr_valid  in  1  host write request
- wr_ready  out  1  host write accepted this cycle when wr_valid is also high
- wr_addr  in  ADDR_W  host pixel address (y*H_IMAGE + x)
- wr_data  in  PIXEL_W  host pixel value
- fill_start  in  1  one-cycle pulse to begin a fill
- fill_color  in  PIXEL_W  fill value, sampled on an accepted fill_start
- fill_busy  out  1  high while a fill is in progress
- fill_done  out  1  one-cycle pulse when a fill completes
- mem_addr  out  ADDR_W  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  PIXEL_W  RAM write data, registered
- mem_rdata  in  PIXEL_W  RAM read data, valid 1 cycle after mem_addr
- color_r, color_g, color_b  out  1 each  pixel colour, registered

Behaviour:
- Reset: reset_n low asynchronously clears:
  - all counters, so the read counter and fill address are 0;
  - the FSM, to IDLE;
  - the outputs mem_addr, mem_we, mem_wdata, colors, fill_busy and fill_done, all to 0.
  - A fill in progress is aborted; the RAM keeps its partial contents.
- Display slot: disp = (pixel_x < H_IMAGE) & (pixel_y < V_IMAGE) & video_on.
- Arbitration: fixed priority per cycle. Display beats fill, and fill beats host write. Exactly one RAM access per cycle at most.
- Read counter rd_cnt:
  - increments on every disp cycle;
  - wraps from H_IMAGE*V_IMAGE-1 to 0;
  - is forced to 0 on any cycle with pixel_y >= V_IMAGE, which resyncs it every frame.
- Display latency is 3 cycles, fixed:
  - cycle t: disp is high;
  - t+1: mem_addr = rd_cnt (value at t), mem_we = 0;
  - t+2: mem_rdata is valid;
  - t+3: colour outputs show that data.
  - If disp was low at t, the colours at t+3 are 0.
  - The top level delays hsync/vsync by 3 to match.
- FSM states: IDLE, FILL, DONE.
  - IDLE:
    - wr_ready = !disp.
    - A handshake (wr_valid & wr_ready) registers mem_addr = wr_addr and mem_wdata = wr_data.
    - mem_we = 1 only if wr_addr < H_IMAGE*V_IMAGE. An out-of-range write is accepted and dropped.
    - fill_start moves the FSM to FILL: fill_addr is set to 0 and fill_color is latched. A host write in the same cycle is still performed.
  - FILL:
    - fill_busy = 1 and wr_ready = 0; fill_start is ignored.
    - Each !disp cycle writes the latched colour to fill_addr, then increments fill_addr.
    - disp cycles stall the fill.
    - After the write to H_IMAGE*V_IMAGE-1 the FSM goes to DONE.
  - DONE: fill_done = 1 for exactly one cycle, fill_busy = 0, wr_ready = 0; next state is IDLE.
- Idle RAM cycles: mem_we = 0 and mem_addr holds its previous value.
- Write-then-read hazard: a read the cycle after a write to the same address returns the new data, provided the RAM is write-first. The arbiter makes no further guarantee.

Test Plan:
- Reset release, video_on = 0, no requests -> all outputs stay 0; wr_ready = 1; fill_busy = 0.
- RAM preloaded with mem[k] = k mod 8, scan of frame 1 -> pixel (0,0) colours = 000 at t+3; pixel (5,0) gives 101; pixel (0,1) gives mem[240] = 0; pixel (240,0) colours = 0; second frame starts again at address 0.
- Host write wr_addr = 481, wr_data = 3'b110 while pixel_x = 300 -> wr_ready = 1, one cycle of mem_we with mem_addr = 481. The same write during disp -> wr_ready = 0 until disp falls. Write to wr_addr = 76800 -> accepted, mem_we stays 0.
- fill_start with fill_color = 3'b011 while video_on = 0 -> fill_busy for exactly 76800 cycles; all addresses 0..76799 written with 011; fill_done pulses once; FSM back to IDLE.
- Fill during active video -> only !disp cycles write; display reads are never delayed; fill_done arrives after 76800 write cycles. fill_start while busy -> ignored.
- reset_n asserted mid-fill at fill_addr = 1000 -> outputs immediately 0; after release FSM is IDLE and addresses >= 1000 are untouched.
